// File: rtl/ub_arbiter.sv
// Unified-buffer arbiter: grants one of fifo(0)/compute(1)/store(2) per op, runs IDLE->ISSUE->WAIT.
// Optional UB_ARB_RR_EN selects round-robin arbitration; default is fixed priority compute > store > fifo.
module ub_arbiter #(
    parameter int BUFFER_SIZE   = 1024,
    parameter int ADDRESS_SIZE  = $clog2(BUFFER_SIZE),
    parameter int COMPUTE_WORDS = 16,
    parameter int DONE_TIMEOUT  = 15,
    parameter int TO_W          = $clog2(DONE_TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fifo_req,
    input  logic                    fifo_wr,
    input  logic                    fifo_section,
    input  logic [ADDRESS_SIZE-1:0] fifo_addr,
    output logic                    fifo_ack,
    input  logic                    cmp_req,
    input  logic                    cmp_wr,
    input  logic [ADDRESS_SIZE-1:0] cmp_addr,
    output logic                    cmp_ack,
    output logic                    cmp_err,
    input  logic                    st_req,
    input  logic                    st_wr,
    input  logic [ADDRESS_SIZE-1:0] st_addr,
    output logic                    st_ack,
    output logic                    ub_we,
    output logic                    ub_re,
    output logic                    ub_compute_en,
    output logic                    ub_fifo_en,
    output logic                    ub_store_en,
    output logic                    ub_section,
    output logic [ADDRESS_SIZE-1:0] ub_address,
    input  logic                    ub_done,
    output logic                    busy,
    output logic [1:0]              grant_id,
    output logic                    timeout_err,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

    localparam logic [ADDRESS_SIZE-1:0] MAX_CMP_ADDR = ADDRESS_SIZE'(BUFFER_SIZE - COMPUTE_WORDS);
    localparam logic [TO_W-1:0]         TO_LAST      = TO_W'(DONE_TIMEOUT - 1);

    state_t                  r_state, w_nxt_state;
    logic [TO_W-1:0]         r_to_cnt, w_nxt_to_cnt;
    logic [1:0]              r_grant_id, w_nxt_grant_id;
    logic [5:0]              r_ctl, w_nxt_ctl;       // {we, re, compute_en, fifo_en, store_en, section}
    logic [ADDRESS_SIZE-1:0] r_address, w_nxt_address;
    logic [2:0]              r_ack, w_nxt_ack;       // bit i = requester id i
    logic                    r_cmp_err, w_nxt_cmp_err;
    logic                    r_timeout_err, w_nxt_timeout_err;

    logic [2:0]              w_reqs;
    logic                    w_win_valid;
    logic [1:0]              w_win_id;
    logic                    w_win_wr;
    logic                    w_win_section;
    logic [ADDRESS_SIZE-1:0] w_win_addr;
    logic                    w_cmp_reject;

    assign w_reqs = {st_req, cmp_req, fifo_req};

`ifdef UB_ARB_RR_EN
    logic [1:0] r_rr_ptr, w_nxt_rr_ptr;

    // Search starts at r_rr_ptr, which always holds (last grant + 1) mod 3.
    always_comb begin : rr_pick
        int idx;
        w_win_valid = 1'b0;
        w_win_id    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= 3) idx = idx - 3;
            if (!w_win_valid && w_reqs[2'(idx)]) begin
                w_win_valid = 1'b1;
                w_win_id    = 2'(idx);
            end
        end
    end

    always_comb begin
        w_nxt_rr_ptr = r_rr_ptr;
        if (r_state == S_IDLE && w_win_valid)
            w_nxt_rr_ptr = (w_win_id == 2'd2) ? 2'd0 : w_win_id + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rr_ptr <= 2'd0;
        else        r_rr_ptr <= w_nxt_rr_ptr;
    end
`else
    always_comb begin
        w_win_valid = |w_reqs;
        if (cmp_req)     w_win_id = 2'd1;
        else if (st_req) w_win_id = 2'd2;
        else             w_win_id = 2'd0;
    end
`endif

    always_comb begin
        w_win_wr      = fifo_wr;
        w_win_section = fifo_section;
        w_win_addr    = fifo_addr;
        if (w_win_id == 2'd1) begin
            w_win_wr      = cmp_wr;
            w_win_section = 1'b0;
            w_win_addr    = cmp_addr;
        end else if (w_win_id == 2'd2) begin
            w_win_wr      = st_wr;
            w_win_section = 1'b0;
            w_win_addr    = st_addr;
        end
    end

    assign w_cmp_reject = (w_win_id == 2'd1) && (cmp_addr > MAX_CMP_ADDR);

    // Buffer controls are computed one state ahead so the registered ub_* lines are high exactly in ISSUE.
    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_to_cnt      = r_to_cnt;
        w_nxt_grant_id    = r_grant_id;
        w_nxt_ctl         = 6'b0;
        w_nxt_address     = '0;
        w_nxt_ack         = 3'b0;
        w_nxt_cmp_err     = 1'b0;
        w_nxt_timeout_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_valid) begin
                    if (w_cmp_reject) begin
                        w_nxt_ack     = 3'b010;
                        w_nxt_cmp_err = 1'b1;
                    end else begin
                        w_nxt_state    = S_ISSUE;
                        w_nxt_grant_id = w_win_id;
                        w_nxt_address  = w_win_addr;
                        w_nxt_ctl      = {w_win_wr, !w_win_wr,
                                          w_win_id == 2'd1, w_win_id == 2'd0, w_win_id == 2'd2,
                                          w_win_section};
                    end
                end
            end
            S_ISSUE: begin
                w_nxt_state  = S_WAIT;
                w_nxt_to_cnt = '0;
            end
            S_WAIT: begin
                if (ub_done) begin
                    w_nxt_ack      = 3'b001 << r_grant_id;
                    w_nxt_grant_id = 2'd3;
                    w_nxt_state    = S_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_nxt_timeout_err = 1'b1;
                    w_nxt_grant_id    = 2'd3;
                    w_nxt_to_cnt      = '0;
                    w_nxt_state       = S_IDLE;
                end else begin
                    w_nxt_to_cnt = r_to_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state    = S_IDLE;
                w_nxt_grant_id = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_to_cnt      <= '0;
            r_grant_id    <= 2'd3;
            r_ctl         <= 6'b0;
            r_address     <= '0;
            r_ack         <= 3'b0;
            r_cmp_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_to_cnt      <= w_nxt_to_cnt;
            r_grant_id    <= w_nxt_grant_id;
            r_ctl         <= w_nxt_ctl;
            r_address     <= w_nxt_address;
            r_ack         <= w_nxt_ack;
            r_cmp_err     <= w_nxt_cmp_err;
            r_timeout_err <= w_nxt_timeout_err;
        end
    end

    assign {ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section} = r_ctl;
    assign ub_address  = r_address;
    assign {st_ack, cmp_ack, fifo_ack} = r_ack;
    assign cmp_err     = r_cmp_err;
    assign timeout_err = r_timeout_err;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;

endmodule
